// File: rtl/poly1305_pkg.sv
// poly1305_pkg
//   Shared definitions for the Poly1305 message-level controller:
//   controller state encoding, key/block widths, the bit ranges of the
//   r and s halves inside the 256-bit one-time key, and the byte count
//   that marks a full 16-byte block.
package poly1305_pkg;

    localparam int KEY_BITS   = 256;
    localparam int BLOCK_BITS = 128;

    // One-time key layout: r in the low half, s in the high half.
    localparam int R_LSB = 0;
    localparam int R_MSB = 127;
    localparam int S_LSB = 128;
    localparam int S_MSB = 255;

    // block_bytes_minus_one value of a full 16-byte block.
    localparam logic [3:0] FULL_BLOCK_BYTES_MINUS_ONE = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR_ENC  = 3'd1,
        ST_WAIT_BLOCK = 3'd2,
        ST_START      = 3'd3,
        ST_COMPUTE    = 3'd4,
        ST_TAG        = 3'd5
    } poly_state_e;

endpackage

// File: rtl/poly1305_block_scheduler.sv
// poly1305_block_scheduler
//   Message-level controller for the Poly1305 serial encoder. Accepts a
//   one-time key and a stream of 128-bit message blocks, sequences the
//   encoder (clear, one start per block, fixed compute wait) and returns
//   the final 128-bit tag.
//
//   Handshakes: every channel uses valid/ready; a transfer happens on a
//   rising clock edge where both valid and ready are high. Offers made
//   while the matching ready is low are ignored and may be withdrawn.
//
// Ports
//   clock, clear                     clock and async active-high reset
//   key, key_empty, key_valid        one-time key offer (r=[127:0], s=[255:128])
//   key_ready                        high only in IDLE
//   block_data, block_bytes_minus_one, block_last, block_valid
//                                    message block offer
//   block_ready                      high only in WAIT_BLOCK
//   enc_clear, enc_start, enc_key, enc_round_input,
//   enc_number_of_input_bytes_minus_one
//                                    drive the serial encoder
//   enc_tag                          encoder tag output
//   tag, tag_valid, tag_ready        result channel
//   busy                             controller not IDLE
//   protocol_error                   sticky: a partial non-last block was seen
module poly1305_block_scheduler
    import poly1305_pkg::*;
#(
    parameter int BLOCK_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [KEY_BITS-1:0]   key,
    input  logic                  key_empty,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [BLOCK_BITS-1:0] block_data,
    input  logic [3:0]            block_bytes_minus_one,
    input  logic                  block_last,
    input  logic                  block_valid,
    output logic                  block_ready,
    output logic                  enc_clear,
    output logic                  enc_start,
    output logic [KEY_BITS-1:0]   enc_key,
    output logic [BLOCK_BITS-1:0] enc_round_input,
    output logic [3:0]            enc_number_of_input_bytes_minus_one,
    input  logic [BLOCK_BITS-1:0] enc_tag,
    output logic [BLOCK_BITS-1:0] tag,
    output logic                  tag_valid,
    input  logic                  tag_ready,
    output logic                  busy,
    output logic                  protocol_error
);

    // Counter only needs to hold BLOCK_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLOCK_CYCLES - 1);

    poly_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [BLOCK_BITS-1:0] round_q, round_d;
    logic [3:0]            nbytes_q, nbytes_d;
    logic                  last_q, last_d;
    logic [BLOCK_BITS-1:0] tag_q, tag_d;
    logic                  perr_q, perr_d;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            round_q  <= '0;
            nbytes_q <= '0;
            last_q   <= 1'b0;
            tag_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            round_q  <= round_d;
            nbytes_q <= nbytes_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        round_d  = round_q;
        nbytes_d = nbytes_q;
        last_d   = last_q;
        tag_d    = tag_q;
        perr_d   = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    key_d = key;
                    if (key_empty) begin
                        // Empty message: the tag is just s; encoder untouched.
                        tag_d   = key[S_MSB:S_LSB];
                        state_d = ST_TAG;
                    end else begin
                        state_d = ST_CLEAR_ENC;
                    end
                end
            end

            ST_CLEAR_ENC: begin
                state_d = ST_WAIT_BLOCK;
            end

            ST_WAIT_BLOCK: begin
                if (block_valid) begin
                    round_d  = block_data;
                    nbytes_d = block_bytes_minus_one;
                    last_d   = block_last;
                    // Only the final block may be short; flag but still process.
                    if (!block_last && (block_bytes_minus_one != FULL_BLOCK_BYTES_MINUS_ONE)) begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                if (cnt_q == '0) begin
                    if (last_q) begin
                        tag_d   = enc_tag;
                        state_d = ST_TAG;
                    end else begin
                        state_d = ST_WAIT_BLOCK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_TAG: begin
                if (tag_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status and strobes decode straight from state so an asynchronous
    // clear forces them to their idle values in the same cycle.
    assign key_ready      = (state_q == ST_IDLE);
    assign block_ready    = (state_q == ST_WAIT_BLOCK);
    assign enc_clear      = clear | (state_q == ST_CLEAR_ENC);
    assign enc_start      = (state_q == ST_START);
    assign tag_valid      = (state_q == ST_TAG);
    assign busy           = (state_q != ST_IDLE);

    assign enc_key                             = key_q;
    assign enc_round_input                     = round_q;
    assign enc_number_of_input_bytes_minus_one = nbytes_q;
    assign tag                                 = tag_q;
    assign protocol_error                      = perr_q;

endmodule

// File: tb/tb_poly1305_block_scheduler.sv
// Testbench for poly1305_block_scheduler. Includes a behavioural Poly1305
// encoder stand-in (tag only final BLOCK_CYCLES cycles after start) and a
// message-level reference that computes the expected tag from the blocks.
module tb_poly1305_block_scheduler;

  localparam int BC = 8;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam int TMO = 200;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic [255:0] key = '0;
  logic         key_empty = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] block_data = '0;
  logic [3:0]   block_bytes_minus_one = '0;
  logic         block_last = 1'b0;
  logic         block_valid = 1'b0;
  logic         block_ready;
  logic         enc_clear;
  logic         enc_start;
  logic [255:0] enc_key;
  logic [127:0] enc_round_input;
  logic [3:0]   enc_nbm1;
  logic [127:0] enc_tag;
  logic [127:0] tag;
  logic         tag_valid;
  logic         tag_ready = 1'b0;
  logic         busy;
  logic         protocol_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic perr_exp = 1'b0;

  logic [127:0] blk_data[$];
  logic [3:0]   blk_bm1[$];

  poly1305_block_scheduler #(.BLOCK_CYCLES(BC)) dut (
    .clock(clock), .clear(clear),
    .key(key), .key_empty(key_empty), .key_valid(key_valid), .key_ready(key_ready),
    .block_data(block_data), .block_bytes_minus_one(block_bytes_minus_one),
    .block_last(block_last), .block_valid(block_valid), .block_ready(block_ready),
    .enc_clear(enc_clear), .enc_start(enc_start), .enc_key(enc_key),
    .enc_round_input(enc_round_input), .enc_number_of_input_bytes_minus_one(enc_nbm1),
    .enc_tag(enc_tag), .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .busy(busy), .protocol_error(protocol_error)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (enc_start) start_cnt <= start_cnt + 1;

  // ---------------- Poly1305 arithmetic ----------------
  function automatic logic [129:0] mac_step(input logic [129:0] acc, input logic [128:0] n,
                                            input logic [127:0] r);
    logic [263:0] x, p, m;
    p = (264'd1 << 130) - 264'd5;
    m = (264'd1 << 130) - 264'd1;
    x = (264'(acc) + 264'(n)) * 264'(r);
    for (int i = 0; i < 3; i++) x = (x & m) + 264'd5 * (x >> 130);
    if (x >= p) x = x - p;
    if (x >= p) x = x - p;
    return x[129:0];
  endfunction

  function automatic logic [128:0] pad_block(input logic [127:0] d, input logic [3:0] bm1);
    logic [128:0] v;
    int n;
    n = int'(bm1) + 1;
    v = '0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = d[8*j +: 8];
    v[8*n] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] ref_tag(input logic [255:0] k);
    logic [129:0] acc;
    acc = '0;
    foreach (blk_data[i]) acc = mac_step(acc, pad_block(blk_data[i], blk_bm1[i]), k[127:0] & CLAMP);
    return acc[127:0] + k[255:128];
  endfunction

  // ---------------- encoder stand-in ----------------
  logic [129:0] m_acc = '0;
  logic [127:0] m_s = '0;
  int           m_cnt = 0;
  logic [127:0] m_rin = '0;
  logic [255:0] m_key = '0;
  logic [3:0]   m_nb = '0;

  always @(posedge clock) begin
    if (enc_clear) begin
      m_acc <= '0;
      m_cnt <= 0;
    end else if (enc_start) begin
      m_acc <= mac_step(m_acc, pad_block(enc_round_input, enc_nbm1), enc_key[127:0] & CLAMP);
      m_s   <= enc_key[255:128];
      m_rin <= enc_round_input;
      m_key <= enc_key;
      m_nb  <= enc_nbm1;
      m_cnt <= BC - 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Before the compute time has elapsed the tag reads as garbage.
  assign enc_tag = (m_cnt == 0) ? (m_acc[127:0] + m_s) : ~(m_acc[127:0] + m_s);

  // Encoder inputs must hold while the encoder is computing.
  always @(negedge clock) begin
    if (m_cnt > 0 && !clear) begin
      vectors++;
      if (enc_round_input !== m_rin || enc_key !== m_key || enc_nbm1 !== m_nb) begin
        miscompares++;
        $display("FAIL enc_hold cyc=%0d got rin=%h nb=%h want rin=%h nb=%h",
                 cyc, enc_round_input, enc_nbm1, m_rin, m_nb);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic gen_msg(input int nblk, input int short_idx);
    blk_data.delete();
    blk_bm1.delete();
    for (int i = 0; i < nblk; i++) begin
      logic [127:0] d;
      logic [3:0] bm1;
      d = {$urandom, $urandom, $urandom, $urandom};
      bm1 = (i == nblk - 1) ? 4'($urandom_range(0, 15)) : 4'd15;
      if (i == short_idx) bm1 = 4'd7;
      for (int j = int'(bm1) + 1; j < 16; j++) d[8*j +: 8] = 8'h00;
      blk_data.push_back(d);
      blk_bm1.push_back(bm1);
    end
  endtask

  task automatic load_rfc(output logic [255:0] k, output logic [127:0] t);
    logic [7:0] kb[32] = '{8'h85,8'hd6,8'hbe,8'h78,8'h57,8'h55,8'h6d,8'h33,
                           8'h7f,8'h44,8'h52,8'hfe,8'h42,8'hd5,8'h06,8'ha8,
                           8'h01,8'h03,8'h80,8'h8a,8'hfb,8'h0d,8'hb2,8'hfd,
                           8'h4a,8'hbf,8'hf6,8'haf,8'h41,8'h49,8'hf5,8'h1b};
    logic [7:0] tb[16] = '{8'ha8,8'h06,8'h1d,8'hc1,8'h30,8'h51,8'h36,8'hc6,
                           8'hc2,8'h2b,8'h8b,8'haf,8'h0c,8'h01,8'h27,8'ha9};
    string m;
    m = "Cryptographic Forum Research Group";
    for (int i = 0; i < 32; i++) k[8*i +: 8] = kb[i];
    for (int i = 0; i < 16; i++) t[8*i +: 8] = tb[i];
    blk_data.delete();
    blk_bm1.delete();
    for (int off = 0; off < m.len(); off += 16) begin
      logic [127:0] d;
      int n;
      n = (m.len() - off < 16) ? (m.len() - off) : 16;
      d = '0;
      for (int j = 0; j < n; j++) d[8*j +: 8] = m[off + j];
      blk_data.push_back(d);
      blk_bm1.push_back(4'(n - 1));
    end
  endtask

  // Driver tasks start and end on a falling edge.
  task automatic send_key(input logic [255:0] k, input logic empty, output int hs);
    int n;
    key = k;
    key_empty = empty;
    key_valid = 1'b1;
    n = 0;
    while (key_ready !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    vectors++;
    if (n >= TMO) begin
      miscompares++;
      $display("FAIL key_timeout got no key_ready want key_ready within %0d cycles", TMO);
    end
    hs = cyc;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic send_block(input int idx, input int exp_rdy, input int gap, output int b);
    int n;
    logic last;
    n = 0;
    while (block_ready !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    vectors++;
    if (cyc !== exp_rdy) begin
      miscompares++;
      $display("FAIL block_ready_cycle blk=%0d got %0d want %0d", idx, cyc, exp_rdy);
    end
    repeat (gap) @(negedge clock);
    last = (idx == blk_data.size() - 1);
    block_data = blk_data[idx];
    block_bytes_minus_one = blk_bm1[idx];
    block_last = last;
    block_valid = 1'b1;
    b = cyc;
    vectors++;
    if (protocol_error !== perr_exp) begin
      miscompares++;
      $display("FAIL perr_before blk=%0d got %b want %b", idx, protocol_error, perr_exp);
    end
    if (!last && blk_bm1[idx] != 4'd15) perr_exp = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    block_data = {$urandom, $urandom, $urandom, $urandom};
    vectors++;
    if (enc_start !== 1'b1 || enc_round_input !== blk_data[idx] || enc_nbm1 !== blk_bm1[idx]) begin
      miscompares++;
      $display("FAIL enc_drive blk=%0d got start=%b rin=%h nb=%h want start=1 rin=%h nb=%h",
               idx, enc_start, enc_round_input, enc_nbm1, blk_data[idx], blk_bm1[idx]);
    end
    vectors++;
    if (protocol_error !== perr_exp) begin
      miscompares++;
      $display("FAIL perr_after blk=%0d got %b want %b", idx, protocol_error, perr_exp);
    end
  endtask

  // Runs one full message from the blk_* queues (or an empty one).
  task automatic run_message(input logic [255:0] k, input logic empty, input logic early,
                             input int stall, input logic [127:0] exp_tag,
                             output int hs, output int t);
    int b, exp_rdy, exp_tv, n;
    logic [127:0] held;
    send_key(k, empty, hs);
    if (empty) begin
      vectors++;
      if (enc_clear !== 1'b0) begin
        miscompares++;
        $display("FAIL empty_no_clear got %b want 0", enc_clear);
      end
      exp_tv = hs + 1;
    end else begin
      vectors++;
      if (enc_clear !== 1'b1 || enc_key !== k) begin
        miscompares++;
        $display("FAIL enc_clear_pulse got clr=%b key=%h want clr=1 key=%h", enc_clear, enc_key, k);
      end
      exp_rdy = hs + 2;
      b = 0;
      for (int i = 0; i < blk_data.size(); i++) begin
        send_block(i, exp_rdy, $urandom_range(0, 2), b);
        exp_rdy = b + 2 + BC;
      end
      exp_tv = b + 2 + BC;
    end
    n = 0;
    while (tag_valid !== 1'b1 && n < TMO) begin @(negedge clock); n++; end
    vectors++;
    if (cyc !== exp_tv) begin
      miscompares++;
      $display("FAIL tag_valid_cycle got %0d want %0d", cyc, exp_tv);
    end
    vectors++;
    if (tag !== exp_tag) begin
      miscompares++;
      $display("FAIL tag_value got %h want %h", tag, exp_tag);
    end
    held = exp_tag;
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        key_valid = 1'b1;
        block_valid = 1'b1;
        @(negedge clock);
        vectors++;
        if (tag !== held || tag_valid !== 1'b1 || key_ready !== 1'b0 ||
            block_ready !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL tag_stall i=%0d got tag=%h tv=%b kr=%b br=%b busy=%b want tag=%h tv=1 kr=0 br=0 busy=1",
                   i, tag, tag_valid, key_ready, block_ready, busy, held);
        end
      end
      key_valid = 1'b0;
      block_valid = 1'b0;
      tag_ready = 1'b1;
    end
    t = cyc;
    @(negedge clock);
    if (!early) tag_ready = 1'b0;
    vectors++;
    if (key_ready !== 1'b1 || tag_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tag_release got kr=%b tv=%b want kr=1 tv=0", key_ready, tag_valid);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    perr_exp = 1'b0;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || block_ready !== 1'b0 || tag_valid !== 1'b0 ||
        enc_start !== 1'b0 || enc_clear !== 1'b1 || protocol_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got kr=%b busy=%b br=%b tv=%b st=%b clr=%b pe=%b want 1 0 0 0 0 1 0",
               key_ready, busy, block_ready, tag_valid, enc_start, enc_clear, protocol_error);
    end
    vectors++;
    if (tag !== '0 || enc_key !== '0 || enc_round_input !== '0 || enc_nbm1 !== '0) begin
      miscompares++;
      $display("FAIL reset_data got tag=%h rin=%h nb=%h want zeros", tag, enc_round_input, enc_nbm1);
    end
    clear = 1'b0;
    @(negedge clock);
    vectors++;
    if (enc_clear !== 1'b0 || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got clr=%b kr=%b want clr=0 kr=1", enc_clear, key_ready);
    end
  endtask

  task automatic test_rfc();
    logic [255:0] k;
    logic [127:0] t_exp;
    int hs, t;
    load_rfc(k, t_exp);
    run_message(k, 1'b0, 1'b0, 2, t_exp, hs, t);
  endtask

  task automatic test_empty();
    logic [255:0] k;
    int hs, t, s0;
    k = {128'h0102030405060708090a0b0c0d0e0f10, $urandom, $urandom, $urandom, $urandom};
    s0 = start_cnt;
    run_message(k, 1'b1, 1'b0, 1, 128'h0102030405060708090a0b0c0d0e0f10, hs, t);
    vectors++;
    if (start_cnt !== s0) begin
      miscompares++;
      $display("FAIL empty_no_start got %0d pulses want 0", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k1, k2;
    int hs1, t1, hs2, t2;
    k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tag_ready = 1'b1;
    gen_msg(2, -1);
    run_message(k1, 1'b0, 1'b1, 0, ref_tag(k1), hs1, t1);
    gen_msg(3, -1);
    run_message(k2, 1'b0, 1'b1, 0, ref_tag(k2), hs2, t2);
    tag_ready = 1'b0;
    vectors++;
    if (hs2 !== t1 + 1) begin
      miscompares++;
      $display("FAIL b2b_key_cycle got %0d want %0d", hs2, t1 + 1);
    end
  endtask

  task automatic test_tag_stall();
    logic [255:0] k;
    int hs, t;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    gen_msg(1, -1);
    run_message(k, 1'b0, 1'b0, 20, ref_tag(k), hs, t);
  endtask

  task automatic test_protocol_error();
    logic [255:0] k;
    int hs, t;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    gen_msg(3, 1);
    run_message(k, 1'b0, 1'b0, 1, ref_tag(k), hs, t);
    vectors++;
    if (protocol_error !== 1'b1) begin
      miscompares++;
      $display("FAIL perr_sticky_after_tag got %b want 1", protocol_error);
    end
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    gen_msg(2, -1);
    run_message(k, 1'b0, 1'b0, 0, ref_tag(k), hs, t);
    pulse_clear();
    vectors++;
    if (protocol_error !== 1'b0) begin
      miscompares++;
      $display("FAIL perr_cleared got %b want 0", protocol_error);
    end
  endtask

  task automatic test_clear_mid();
    logic [255:0] k;
    logic [127:0] t_exp;
    int hs, b, t;
    load_rfc(k, t_exp);
    send_key(k, 1'b0, hs);
    send_block(0, hs + 2, 0, b);
    send_block(1, b + 2 + BC, 1, b);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    #1;
    vectors++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || block_ready !== 1'b0 || tag_valid !== 1'b0 ||
        enc_start !== 1'b0 || enc_clear !== 1'b1 || protocol_error !== 1'b0 ||
        tag !== '0 || enc_key !== '0 || enc_round_input !== '0 || enc_nbm1 !== '0) begin
      miscompares++;
      $display("FAIL clear_mid got kr=%b busy=%b br=%b tv=%b st=%b clr=%b rin=%h want reset values",
               key_ready, busy, block_ready, tag_valid, enc_start, enc_clear, enc_round_input);
    end
    @(negedge clock);
    clear = 1'b0;
    perr_exp = 1'b0;
    @(negedge clock);
    load_rfc(k, t_exp);
    run_message(k, 1'b0, 1'b0, 0, t_exp, hs, t);
  endtask

  task automatic test_random();
    logic [255:0] k;
    int hs, t;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      gen_msg($urandom_range(1, 4), -1);
      run_message(k, 1'b0, 1'b0, $urandom_range(0, 3), ref_tag(k), hs, t);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_rfc();
    test_empty();
    test_back_to_back();
    test_tag_stall();
    test_protocol_error();
    test_clear_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
